// File: rtl/sdr_line_fetch_pkg.sv
// Shared constants and fetch FSM state encoding for the SDRAM line fill engine.
package sdr_line_fetch_pkg;

  localparam int SDR_BURST_BEATS = 4;
  localparam int SDR_BEAT_W      = 16;
  // Byte-offset bits inside one cache line; the caller supplies region bits above.
  localparam int SDR_LINE_ALIGN  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BEATS,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/sdr_beat_packer.sv
// Writes one controller beat into its slot of the assembled cache line.
module sdr_beat_packer
  import sdr_line_fetch_pkg::*;
#(
  parameter int BEATS  = SDR_BURST_BEATS,
  parameter int DATA_W = SDR_BEAT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(BEATS)-1:0]   beat,
  input  logic [DATA_W-1:0]          data,
  output logic [BEATS*DATA_W-1:0]    line_data
);

  localparam int BEAT_W = $clog2(BEATS);

  always_ff @(posedge clk) begin
    if (reset) begin
      line_data <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        if (wr_en && beat == BEAT_W'(i)) begin
          line_data[i*DATA_W +: DATA_W] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/sdr_line_fetch.sv
// SDRAM-side fill engine: one burst read per line request, beats packed into a line.
module sdr_line_fetch
  import sdr_line_fetch_pkg::*;
#(
  parameter int BEATS  = SDR_BURST_BEATS,
  parameter int ADDR_W = 25,
  parameter int DATA_W = SDR_BEAT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic [BEATS*DATA_W-1:0] line_data,
  output logic                    line_rdy,
  output logic                    busy,
  output logic [ADDR_W-1:0]       ctrl_addr,
  output logic                    ctrl_req,
  input  logic                    ctrl_ack,
  input  logic [DATA_W-1:0]       ctrl_data,
  input  logic                    ctrl_valid
);

  localparam int                BEAT_W    = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  fetch_state_e      state, state_d, drain_state;
  logic [BEAT_W-1:0] beat, beat_d, drain_beat;
  logic [ADDR_W-1:0] ctrl_addr_d, slot_addr, req_aligned;
  logic              slot_full, slot_load, take_slot;
  logic              line_rdy_d, wr_en, beat_active;
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  assign req_aligned = req_addr & ~ADDR_W'((1 << SDR_LINE_ALIGN) - 1);
  assign beat_active = (state == S_BEATS) || (state == S_DRAIN);
  assign ctrl_req    = (state == S_ISSUE);
  assign busy        = (state != S_IDLE) || slot_full;

  // Stage p0: controller beats registered; beats outside a burst never enter
  always_ff @(posedge clk) begin
    vld_p0  <= ctrl_valid && beat_active;
    data_p0 <= ctrl_data;
  end

  always_comb begin
    state_d     = state;
    beat_d      = beat;
    ctrl_addr_d = ctrl_addr;
    line_rdy_d  = 1'b0;
    take_slot   = 1'b0;
    wr_en       = 1'b0;
    slot_load   = req && !(state == S_IDLE && !slot_full);
    // Drain progression is shared with reset so an acked burst is still counted out.
    drain_state = S_DRAIN;
    drain_beat  = beat;
    if (vld_p0) begin
      drain_beat = beat + 1'b1;
      if (beat == LAST_BEAT) begin
        drain_state = S_IDLE;
        drain_beat  = '0;
      end
    end
    case (state)
      S_IDLE: begin
        if (slot_full) begin
          ctrl_addr_d = slot_addr;
          take_slot   = 1'b1;
          state_d     = S_ISSUE;
        end else if (req) begin
          ctrl_addr_d = req_aligned;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ctrl_ack) begin
          beat_d  = '0;
          state_d = S_BEATS;
        end
      end
      S_BEATS: begin
        if (vld_p0) begin
          wr_en  = 1'b1;
          beat_d = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            beat_d     = '0;
            line_rdy_d = 1'b1;
            if (slot_full) begin
              ctrl_addr_d = slot_addr;
              take_slot   = 1'b1;
              state_d     = S_ISSUE;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        state_d = drain_state;
        beat_d  = drain_beat;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= beat_active ? drain_state : S_IDLE;
      beat      <= beat_active ? drain_beat : '0;
      ctrl_addr <= '0;
      line_rdy  <= 1'b0;
      slot_full <= 1'b0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      ctrl_addr <= ctrl_addr_d;
      line_rdy  <= line_rdy_d;
      if (take_slot) slot_full <= 1'b0;
      if (slot_load) slot_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && slot_load) slot_addr <= req_aligned;
  end

  sdr_beat_packer #(
    .BEATS  (BEATS),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .beat      (beat),
    .data      (data_p0),
    .line_data (line_data)
  );

endmodule

// File: tb/tb_sdr_line_fetch.sv
// Scoreboard bench for sdr_line_fetch: directed requests, bench acts as SDRAM controller.
module tb_sdr_line_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [24:0] req_addr = '0;
  logic [63:0] line_data;
  logic        line_rdy;
  logic        busy;
  logic [24:0] ctrl_addr;
  logic        ctrl_req;
  logic        ctrl_ack = 1'b0;
  logic [15:0] ctrl_data = '0;
  logic        ctrl_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] data;
    int          rdy_cyc;
    logic        busy;
  } line_exp_t;

  typedef struct {
    logic [24:0] addr;
    logic        with_rdy;
  } cmd_exp_t;

  line_exp_t line_q[$];
  cmd_exp_t  cmd_q[$];

  sdr_line_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .line_data  (line_data),
    .line_rdy   (line_rdy),
    .busy       (busy),
    .ctrl_addr  (ctrl_addr),
    .ctrl_req   (ctrl_req),
    .ctrl_ack   (ctrl_ack),
    .ctrl_data  (ctrl_data),
    .ctrl_valid (ctrl_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [63:0] data, input int rdy_cyc, input logic bsy);
    line_exp_t e;
    e.data = data; e.rdy_cyc = rdy_cyc; e.busy = bsy;
    line_q.push_back(e);
  endtask

  task automatic push_cmd(input logic [24:0] addr, input logic with_rdy);
    cmd_exp_t e;
    e.addr = addr; e.with_rdy = with_rdy;
    cmd_q.push_back(e);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [24:0] held_addr = '0;
  always @(negedge clk) begin
    line_exp_t le;
    cmd_exp_t  ce;
    if (line_rdy) begin
      if (line_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_line_rdy got=line_rdy(data=0x%0h) want=no_pulse", line_data);
      end else begin
        le = line_q.pop_front();
        chk("line_data", line_data, le.data);
        chk("busy_at_rdy", 64'(busy), 64'(le.busy));
        if (le.rdy_cyc >= 0) chk("rdy_cycle", 64'(cyc), 64'(le.rdy_cyc));
      end
    end
    if (ctrl_req && !prev_req) begin
      if (cmd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ctrl_req got=addr 0x%0h want=no_request", ctrl_addr);
      end else begin
        ce = cmd_q.pop_front();
        chk("ctrl_addr", 64'(ctrl_addr), 64'(ce.addr));
        if (ce.with_rdy) chk("req_with_rdy", 64'(line_rdy), 64'd1);
      end
      held_addr = ctrl_addr;
    end else if (ctrl_req) begin
      chk("ctrl_addr_stable", 64'(ctrl_addr), 64'(held_addr));
    end
    if (prev_req && !prev_rst) chk("ctrl_req_hold", 64'(ctrl_req), 64'(!prev_ack));
    prev_req = ctrl_req;
    prev_ack = ctrl_ack;
    prev_rst = reset;
  end

  task automatic wait_req();
    int n = 0;
    while (!ctrl_req && n < 40) begin
      tick();
      n++;
    end
    if (!ctrl_req) begin
      checks++; failures++;
      $display("FAIL wait_ctrl_req got=timeout want=ctrl_req");
    end
  endtask

  task automatic send_ack(input int dly);
    repeat (dly) tick();
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d);
    ctrl_valid = 1'b1;
    ctrl_data  = d;
    tick();
    ctrl_valid = 1'b0;
  endtask

  task automatic serve(input int ack_dly, input logic [15:0] b0, input logic [15:0] b1,
                       input logic [15:0] b2, input logic [15:0] b3,
                       input int gap_after, input int gap_len);
    logic [15:0] b[4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    wait_req();
    send_ack(ack_dly);
    for (int i = 0; i < 4; i++) begin
      send_beat(b[i]);
      if (i == gap_after) repeat (gap_len) tick();
    end
  endtask

  task automatic idle_wait();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
    repeat (2) tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_line_data", line_data, 64'd0);
    chk("rst_line_rdy", 64'(line_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ctrl_req", 64'(ctrl_req), 64'd0);
    chk("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);

    // Spurious valids and ack while idle
    ctrl_valid = 1'b1; ctrl_data = 16'hDEAD; ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    repeat (2) tick();
    ctrl_valid = 1'b0;
    repeat (2) tick();
    chk("spur_line_data", line_data, 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_line_rdy", 64'(line_rdy), 64'd0);

    // Single fetch
    push_cmd(25'h0100008, 1'b0);
    push_line(64'h4444_3333_2222_1111, cyc + 7, 1'b0);
    req = 1'b1; req_addr = 25'h010000F;
    tick();
    req = 1'b0;
    serve(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, -1, 0);
    idle_wait();

    // Stalled controller
    push_cmd(25'h1ABCDE0, 1'b0);
    push_line(64'hD0D1_C0C1_B0B1_A0A1, cyc + 13, 1'b0);
    req = 1'b1; req_addr = 25'h1ABCDE7;
    tick();
    req = 1'b0;
    serve(5, 16'hA0A1, 16'hB0B1, 16'hC0C1, 16'hD0D1, 1, 1);
    idle_wait();

    // Back-to-back: B is overwritten in the slot by C
    push_cmd(25'h0000040, 1'b0);
    push_cmd(25'h00000C0, 1'b0);
    push_line(64'h0A03_0A02_0A01_0A00, cyc + 7, 1'b1);
    push_line(64'h0C03_0C02_0C01_0C00, cyc + 13, 1'b0);
    req = 1'b1; req_addr = 25'h0000040;
    tick();
    req = 1'b0;
    fork
      begin
        serve(0, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, -1, 0);
        serve(0, 16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03, -1, 0);
      end
      begin
        repeat (2) tick();
        req = 1'b1; req_addr = 25'h0000080;
        tick();
        req_addr = 25'h00000C0;
        tick();
        req = 1'b0;
      end
    join
    idle_wait();

    // Request on the same cycle as the final beat
    push_cmd(25'h0000100, 1'b0);
    push_cmd(25'h0000148, 1'b1);
    push_line(64'hE003_E002_E001_E000, cyc + 7, 1'b1);
    push_line(64'hF003_F002_F001_F000, cyc + 13, 1'b0);
    req = 1'b1; req_addr = 25'h0000100;
    tick();
    req = 1'b0;
    fork
      begin
        serve(0, 16'hE000, 16'hE001, 16'hE002, 16'hE003, -1, 0);
        serve(0, 16'hF000, 16'hF001, 16'hF002, 16'hF003, -1, 0);
      end
      begin
        repeat (4) tick();
        req = 1'b1; req_addr = 25'h000014B;
        tick();
        req = 1'b0;
      end
    join
    idle_wait();

    // Reset after beat 1; remaining beats must be drained, not delivered
    push_cmd(25'h0000180, 1'b0);
    req = 1'b1; req_addr = 25'h0000180;
    tick();
    req = 1'b0;
    wait_req();
    send_ack(0);
    send_beat(16'h9000);
    send_beat(16'h9001);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_ctrl_req", 64'(ctrl_req), 64'd0);
    chk("drain_line_cleared", line_data, 64'd0);
    send_beat(16'h9002);
    send_beat(16'h9003);
    repeat (2) tick();
    chk("post_drain_busy", 64'(busy), 64'd0);
    chk("post_drain_line", line_data, 64'd0);
    chk("post_drain_rdy", 64'(line_rdy), 64'd0);

    push_cmd(25'h0000200, 1'b0);
    push_line(64'h2004_2003_2002_2001, cyc + 7, 1'b0);
    req = 1'b1; req_addr = 25'h0000200;
    tick();
    req = 1'b0;
    serve(0, 16'h2001, 16'h2002, 16'h2003, 16'h2004, -1, 0);
    idle_wait();

    n = 0;
    while ((line_q.size() != 0 || cmd_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("lines_outstanding", 64'(line_q.size()), 64'd0);
    chk("cmds_outstanding", 64'(cmd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdr_line_fetch.md
Name: sdr_line_fetch

Overview:
- SDRAM-side fill engine for the CPU ROM cache.
- Accepts a one-cycle line request (25-bit byte address, 8-byte aligned) and issues one 4-beat x 16-bit burst read to the SDRAM controller channel.
- Assembles the beats into a 64-bit line and returns it with a one-cycle ready pulse.
- Runs entirely in the SDRAM clock domain. Sits between the cache's sdr_addr/sdr_req/sdr_data/sdr_rdy port and the controller.

Parameters:
- BEATS, 4, burst length in controller words. Line width = BEATS*16.
- ADDR_W, 25, byte address width.

Ports:
- clk  in  1  SDRAM clock.
- reset  in  1  synchronous, active-high.
- req  in  1  single-cycle line request.
- req_addr  in  25  byte address. Bits [2:0] are ignored and forced to 0.
- line_data  out  64  assembled line. Beat 0 is in [15:0], beat 3 in [63:48].
- line_rdy  out  1  single-cycle pulse; line_data is valid on this cycle and holds until the next line_rdy.
- busy  out  1  high while any request is pending or in flight.
- ctrl_addr  out  25  burst start address to the controller.
- ctrl_req  out  1  level request; held until ctrl_ack.
- ctrl_ack  in  1  controller accepted the command (one cycle).
- ctrl_data  in  16  read beat.
- ctrl_valid  in  1  ctrl_data valid this cycle; exactly BEATS valids follow each ack, not necessarily contiguous.

Behaviour:
- Reset values: line_data=0, line_rdy=0, busy=0, ctrl_req=0, ctrl_addr=0, beat count=0, pending slot empty, state IDLE.
- States:
  - IDLE:
    - req or pending: load ctrl_addr = {addr[24:3],3'b000}, ctrl_req=1, go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - ctrl_ack: ctrl_req=0 on the next cycle, beat=0, go to BEATS.
    - No ack: hold ctrl_req and ctrl_addr stable.
  - BEATS:
    - Each ctrl_valid writes ctrl_data into line_data[16*beat +: 16] and increments beat.
    - On the valid with beat==BEATS-1: line_rdy=1 on the following cycle, return to IDLE.
    - line_data is updated in place during the burst; it may show partial data before line_rdy, and consumers sample only on line_rdy.
  - DRAIN:
    - Discards ctrl_valid beats, counting them, until the outstanding burst completes, then goes to IDLE.
    - line_rdy is never asserted from DRAIN.
- Latency:
  - With ack in the cycle after req and 4 contiguous valids starting in the cycle after ack, line_rdy is asserted exactly 7 cycles after req (req at cycle 0, ack at cycle 1, valids at cycles 2-5, line_rdy at cycle 7).
  - Each cycle of ack or valid delay adds one cycle.
- Pending slot (depth 1):
  - req while not IDLE latches its address into the slot.
  - A second req while the slot is full overwrites the slot (newest wins); the older pending address is dropped.
  - From IDLE, the slot is served before any new simultaneous req. That req is then latched into the slot.
- Simultaneous events:
  - req on the same cycle as the final beat goes into the slot.
  - The slot's request enters ISSUE on the cycle line_rdy is asserted.
- busy = (state!=IDLE) | slot_full.
- Reset mid-operation:
  - Reset in ISSUE or BEATS drops the pending slot, deasserts ctrl_req, and suppresses line_rdy.
  - If an ack was already received, the FSM enters DRAIN when reset falls, with the remaining beat count preserved.
  - Beat count is not cleared by reset in that case. This is the only state carried through reset.
- Spurious inputs:
  - ctrl_valid in IDLE or ISSUE is ignored.
  - ctrl_ack outside ISSUE is ignored.
- Wrap-around:
  - The beat counter is log2(BEATS) bits and never exceeds BEATS-1.
  - Addresses pass through unmodified apart from the alignment; no carry into region bits.

Decomposition:
- In board_pkg: SDR_BURST_BEATS constant and the fetch FSM state enum (IDLE, ISSUE, BEATS, DRAIN).
- Address alignment uses the existing region base constants; the caller forms region bits.
- Natural sub-module: sdr_beat_packer. It takes beat index and data and writes the 64-bit line register, keeping the FSM separate from datapath packing.
- Everything else stays in one module.

Test Plan:
- Single fetch:
  - Stimulus: req_addr=0x0100_00F, ack after 1 cycle, beats 0x1111,0x2222,0x3333,0x4444 contiguous.
  - Required: ctrl_addr=0x0100_008; line_rdy 7 cycles after req; line_data=0x4444_3333_2222_1111.
- Stalled controller:
  - Stimulus: ack delayed 5 cycles, one idle cycle between beats 1 and 2.
  - Required: ctrl_req and ctrl_addr stable throughout; line_rdy exactly once; correct line.
- Back-to-back:
  - Stimulus: req A=0x0000_040, then req B=0x0000_080 during A's beats, then req C=0x0000_0C0 before A completes.
  - Required: bursts issued for A then C only; two line_rdy pulses; busy low only after C.
- Simultaneous:
  - Stimulus: req on the same cycle as A's final valid.
  - Required: line_rdy for A; ctrl_req for the new address is asserted on the same cycle as A's line_rdy.
- Reset mid-burst:
  - Stimulus: reset for 2 cycles after beat 1 of 4; beats 2 and 3 arrive after reset.
  - Required: beats discarded, no line_rdy; next req=0x0000_200 returns its own data correctly.
- Spurious valid:
  - Stimulus: ctrl_valid pulses in IDLE.
  - Required: line_data unchanged (0 after reset), no line_rdy.
